// File: rtl/memorio_bridge.sv
// Load/store router between the execute stage, data memory and the IO bus; IO traffic uses a req/ack FSM that stalls the CPU.
// Optional IO_TIMEOUT_EN macro adds an REQ-state timeout with a sticky Timeout_err flag.
module memorio_bridge #(
    parameter logic [21:0] IO_BASE = 22'h3FFFFF,
    parameter int IO_DW = 16
`ifdef IO_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Mem_read,
    input  logic             Mem_write,
    input  logic [31:0]      Addr_in,
    input  logic [31:0]      Write_data,
    input  logic [31:0]      Mem_rdata,
    output logic [31:0]      Mem_addr,
    output logic [31:0]      Mem_wdata,
    output logic             Mem_wen,
    output logic [9:0]       io_addr,
    output logic [IO_DW-1:0] io_wdata,
    output logic             io_we,
    output logic             io_req,
    input  logic             io_ack,
    input  logic [IO_DW-1:0] io_rdata,
    output logic [31:0]      Rdata,
    output logic             Stall,
    output logic             Timeout_err
);

    // state | meaning
    // IDLE  | no IO transaction; memory path active, IO access latches its operands
    // REQ   | io_req asserted, waiting for io_ack (or timeout)
    // DONE  | IO result presented for one cycle while the CPU commits
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t state, state_nxt;
    logic             is_io;
    logic             timeout_hit;
    logic [9:0]       io_addr_q;
    logic [IO_DW-1:0] io_wdata_q;
    logic             io_we_q;
    logic [31:0]      rd_q;

    assign is_io = (Mem_read | Mem_write) && (Addr_in[31:10] == IO_BASE);

    assign Mem_addr  = Addr_in;
    assign Mem_wdata = Write_data;
    assign Mem_wen   = Mem_write & ~is_io;

    assign io_addr  = io_addr_q;
    assign io_wdata = io_wdata_q;
    assign io_we    = io_we_q;

`ifdef IO_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       tmo_err_q;

    assign timeout_hit = (state == REQ) && !io_ack && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign Timeout_err = tmo_err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt   <= 8'd0;
            tmo_err_q <= 1'b0;
        end else begin
            if (state == IDLE && is_io)
                tmo_cnt <= 8'd0;
            else if (state == REQ)
                tmo_cnt <= tmo_cnt + 8'd1;
            if (timeout_hit)
                tmo_err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign Timeout_err = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // DONE always returns to IDLE so a still-asserted load/store is not re-issued.
    always_comb begin
        state_nxt = state;
        io_req    = 1'b0;
        Stall     = 1'b0;
        Rdata     = Mem_rdata;
        case (state)
            IDLE: begin
                Stall = is_io;
                if (is_io)
                    state_nxt = REQ;
            end
            REQ: begin
                io_req = 1'b1;
                Stall  = 1'b1;
                if (io_ack || timeout_hit)
                    state_nxt = DONE;
            end
            DONE: begin
                Rdata     = io_we_q ? 32'd0 : rd_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_addr_q  <= '0;
            io_wdata_q <= '0;
            io_we_q    <= 1'b0;
            rd_q       <= 32'd0;
        end else begin
            if (state == IDLE && is_io) begin
                io_addr_q  <= Addr_in[9:0];
                io_wdata_q <= Write_data[IO_DW-1:0];
                io_we_q    <= Mem_write;
            end
            if (state == REQ && io_ack)
                rd_q <= 32'(io_rdata);
            else if (timeout_hit)
                rd_q <= 32'hFFFF_FFFF;
        end
    end

endmodule

// File: tb/tb_memorio_bridge.sv
// Directed-vector bench for memorio_bridge: memory path, IO read/write handshakes, reset abort, optional timeout.
module tb_memorio_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic        Mem_read, Mem_write;
    logic [31:0] Addr_in, Write_data, Mem_rdata;
    logic [31:0] Mem_addr, Mem_wdata;
    logic        Mem_wen;
    logic [9:0]  io_addr;
    logic [15:0] io_wdata;
    logic        io_we, io_req, io_ack;
    logic [15:0] io_rdata;
    logic [31:0] Rdata;
    logic        Stall, Timeout_err;

    int vectors = 0;
    int miscompares = 0;

    memorio_bridge dut (
        .clock(clock), .reset(reset),
        .Mem_read(Mem_read), .Mem_write(Mem_write),
        .Addr_in(Addr_in), .Write_data(Write_data), .Mem_rdata(Mem_rdata),
        .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata), .Mem_wen(Mem_wen),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we),
        .io_req(io_req), .io_ack(io_ack), .io_rdata(io_rdata),
        .Rdata(Rdata), .Stall(Stall), .Timeout_err(Timeout_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        Mem_read = 1'b0; Mem_write = 1'b0;
        Addr_in = '0; Write_data = '0; Mem_rdata = '0;
        io_ack = 1'b0; io_rdata = '0;
        tick(); tick();
        check("rst_io_req", 32'(io_req), 32'd0);
        check("rst_io_we", 32'(io_we), 32'd0);
        check("rst_io_addr", 32'(io_addr), 32'd0);
        check("rst_io_wdata", 32'(io_wdata), 32'd0);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_timeout", 32'(Timeout_err), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // 1: memory load
        Mem_read = 1'b1; Addr_in = 32'h0000_0010; Mem_rdata = 32'h1234_5678;
        #1;
        check("lw_rdata", Rdata, 32'h1234_5678);
        check("lw_stall", 32'(Stall), 32'd0);
        check("lw_io_req", 32'(io_req), 32'd0);
        check("lw_addr", Mem_addr, 32'h0000_0010);
        check("lw_wen", 32'(Mem_wen), 32'd0);

        // 2: memory store
        @(negedge clock);
        Mem_read = 1'b0; Mem_write = 1'b1;
        Addr_in = 32'h0000_0020; Write_data = 32'hA5A5_A5A5;
        #1;
        check("sw_wen", 32'(Mem_wen), 32'd1);
        check("sw_wdata", Mem_wdata, 32'hA5A5_A5A5);
        check("sw_stall", 32'(Stall), 32'd0);
        tick();
        check("sw_still_idle", 32'(io_req), 32'd0);

        // io_ack with no IO access is ignored
        @(negedge clock);
        Mem_write = 1'b0; io_ack = 1'b1; io_rdata = 16'h1111;
        tick();
        check("stray_ack_req", 32'(io_req), 32'd0);
        check("stray_ack_stall", 32'(Stall), 32'd0);

        // 3: IO read, ack in first REQ cycle
        @(negedge clock);
        io_ack = 1'b0;
        Mem_read = 1'b1; Addr_in = 32'hFFFF_FC60; Mem_rdata = 32'hDEAD_0000;
        #1;
        check("rd_idle_stall", 32'(Stall), 32'd1);
        check("rd_idle_req", 32'(io_req), 32'd0);
        check("rd_idle_wen", 32'(Mem_wen), 32'd0);
        io_ack = 1'b1; io_rdata = 16'hBEEF;
        tick();
        check("rd_req", 32'(io_req), 32'd1);
        check("rd_req_stall", 32'(Stall), 32'd1);
        check("rd_io_addr", 32'(io_addr), 32'h060);
        check("rd_io_we", 32'(io_we), 32'd0);
        tick();
        check("rd_done_req", 32'(io_req), 32'd0);
        check("rd_done_stall", 32'(Stall), 32'd0);
        check("rd_done_rdata", Rdata, 32'h0000_BEEF);
        io_ack = 1'b0; Mem_read = 1'b0;
        tick();
        check("rd_back_idle_req", 32'(io_req), 32'd0);
        check("rd_back_idle_stall", 32'(Stall), 32'd0);

        // 4: IO write, ack delayed 5 cycles
        @(negedge clock);
        Mem_write = 1'b1; Addr_in = 32'hFFFF_FC62; Write_data = 32'h0000_0055;
        #1;
        check("wr_idle_stall", 32'(Stall), 32'd1);
        check("wr_idle_wen", 32'(Mem_wen), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("wr_req", 32'(io_req), 32'd1);
            check("wr_io_we", 32'(io_we), 32'd1);
            check("wr_io_wdata", 32'(io_wdata), 32'h0055);
            check("wr_io_addr", 32'(io_addr), 32'h062);
            check("wr_wen", 32'(Mem_wen), 32'd0);
            check("wr_stall", 32'(Stall), 32'd1);
            if (i == 6) io_ack = 1'b1;
        end
        tick();
        check("wr_done_req", 32'(io_req), 32'd0);
        check("wr_done_stall", 32'(Stall), 32'd0);
        check("wr_done_rdata", Rdata, 32'd0);
        check("wr_done_wen", 32'(Mem_wen), 32'd0);
        io_ack = 1'b0; Mem_write = 1'b0;
        tick();
        check("wr_back_idle", 32'(io_req), 32'd0);

        // 5: reset in REQ aborts, then a normal read completes
        @(negedge clock);
        Mem_read = 1'b1; Addr_in = 32'hFFFF_FC10;
        tick();
        check("abort_req", 32'(io_req), 32'd1);
        #2;
        reset = 1'b1; Mem_read = 1'b0;
        #1;
        check("abort_io_req", 32'(io_req), 32'd0);
        check("abort_stall", 32'(Stall), 32'd0);
        check("abort_io_addr", 32'(io_addr), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        check("abort_no_retry", 32'(io_req), 32'd0);
        @(negedge clock);
        Mem_read = 1'b1; Addr_in = 32'hFFFF_FC14; io_ack = 1'b1; io_rdata = 16'h1234;
        tick();
        check("post_req", 32'(io_req), 32'd1);
        check("post_io_addr", 32'(io_addr), 32'h014);
        tick();
        check("post_done_rdata", Rdata, 32'h0000_1234);
        check("post_done_stall", 32'(Stall), 32'd0);
        io_ack = 1'b0; Mem_read = 1'b0;
        tick();

`ifdef IO_TIMEOUT_EN
        // 6: no ack -> timeout after 255 REQ cycles
        @(negedge clock);
        Mem_read = 1'b1; Addr_in = 32'hFFFF_FC20;
        tick();
        n = 0;
        while (io_req === 1'b1 && n < 300) begin
            n++;
            tick();
        end
        check("tmo_req_cycles", 32'(n), 32'd255);
        check("tmo_done_rdata", Rdata, 32'hFFFF_FFFF);
        check("tmo_err", 32'(Timeout_err), 32'd1);
        Mem_read = 1'b0;
        tick(); tick();
        check("tmo_err_sticky", 32'(Timeout_err), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("tmo_err_cleared", 32'(Timeout_err), 32'd0);
        @(negedge clock);
        reset = 1'b0;
`else
        n = 0;
        check("tmo_err_off", 32'(Timeout_err), 32'd0);
`endif
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
